// File: rtl/cpu_mem_bus.sv
// Memory/bus stage behind the cpu core: word-addressed RAM, a TX output
// FIFO with a ready/valid drain port, a STATUS word and a single-entry RX
// holding register. Because the core has no request strobe, write and
// read side effects fire on edges of (rw, address) against the previous cycle.
module cpu_mem_bus #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_datao,
    input  logic        cpu_rw,
    output logic [31:0] cpu_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RAM_WORDS = 1 << ADDR_BITS;

    // Storage
    logic [31:0]          ram     [RAM_WORDS];
    logic [31:0]          tx_mem  [FIFO_DEPTH];

    // TX FIFO control
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     tx_count;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 tx_push;
    logic                 tx_drop;
    logic                 tx_pop;
    logic                 overflow;

    // RX holding register
    logic                 rx_full;
    logic [31:0]          rx_data;
    logic                 rx_capture;

    // Edge-detect history of the core's bus outputs
    logic                 prev_rw;
    logic [31:0]          prev_addr;

    // Decode and event qualifiers
    logic [31:0]          mmio_off;
    logic                 in_window;
    logic                 sel_tx;
    logic                 sel_status;
    logic                 sel_rx;
    logic                 sel_ram;
    logic                 wr_event;
    logic                 rd_event;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_idx;
    logic [31:0]          status_word;

    // Region decode, access-edge detection and FIFO/RX handshake qualifiers
    always_comb begin
        mmio_off   = cpu_address - MMIO_BASE;
        in_window  = (mmio_off < 32'd16);
        sel_tx     = in_window && (mmio_off[3:0] == 4'd0);
        sel_status = in_window && (mmio_off[3:0] == 4'd1);
        sel_rx     = in_window && (mmio_off[3:0] == 4'd2);
        sel_ram    = !in_window;
        ram_idx    = cpu_address[ADDR_BITS-1:0];

        wr_event   = !cpu_rw && (prev_rw  || (cpu_address != prev_addr));
        rd_event   =  cpu_rw && (!prev_rw || (cpu_address != prev_addr));

        tx_full    = (tx_count == CNT_W'(FIFO_DEPTH));
        tx_empty   = (tx_count == '0);
        tx_push    = wr_event && sel_tx && !tx_full;
        tx_drop    = wr_event && sel_tx &&  tx_full;
        tx_pop     = !tx_empty && out_ready;
        ram_we     = wr_event && sel_ram;
        rx_capture = in_valid && !rx_full;

        status_word = {16'h0000, 8'(tx_count), 4'h0, rx_full, overflow, tx_empty, tx_full};
    end

    // Combinational read mux back to the core
    always_comb begin
        cpu_data = '0;
        if (cpu_rw) begin
            if (sel_ram)
                cpu_data = ram[ram_idx];
            else if (sel_status)
                cpu_data = status_word;
            else if (sel_rx)
                cpu_data = rx_data;
        end
    end

    // Handshake outputs; FIFO head is masked when empty so no stale/X data leaks
    always_comb begin
        out_valid = !tx_empty;
        out_data  = tx_empty ? '0 : tx_mem[rd_ptr];
        in_ready  = !rx_full;
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (!reset && ram_we)
            ram[ram_idx] <= cpu_datao;
    end

    // TX FIFO storage write
    always_ff @(posedge clock) begin
        if (!reset && tx_push)
            tx_mem[wr_ptr] <= cpu_datao;
    end

    // TX FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tx_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (tx_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
            // set and clear cannot coincide: one is a write event, the other a read event
            if (tx_drop)
                overflow <= 1'b1;
            else if (rd_event && sel_status)
                overflow <= 1'b0;
        end
    end

    // RX holding register: capture from source, pop on a CPU read event
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_full <= 1'b0;
            rx_data <= '0;
        end else if (rx_capture) begin
            rx_full <= 1'b1;
            rx_data <= in_data;
        end else if (rd_event && sel_rx) begin
            rx_full <= 1'b0;
        end
    end

    // Bus history for access-edge detection, registered every cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_rw   <= 1'b1;
            prev_addr <= '0;
        end else begin
            prev_rw   <= cpu_rw;
            prev_addr <= cpu_address;
        end
    end

endmodule

// File: tb/tb_cpu_mem_bus.sv
// Scoreboard bench for cpu_mem_bus: stimulus queues expected values, a
// negedge monitor pops and compares them, and also checks every TX beat.
module tb_cpu_mem_bus;

    localparam int unsigned ADDR_BITS  = 10;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [31:0] BASE       = 32'hFFFF_0000;
    localparam logic [31:0] A_TX       = BASE;
    localparam logic [31:0] A_STATUS   = BASE + 32'd1;
    localparam logic [31:0] A_RX       = BASE + 32'd2;

    localparam int SEL_DATA   = 0;
    localparam int SEL_OVALID = 1;
    localparam int SEL_IREADY = 2;

    logic        clock;
    logic        reset;
    logic [31:0] cpu_address;
    logic [31:0] cpu_datao;
    logic        cpu_rw;
    logic [31:0] cpu_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    int checks   = 0;
    int failures = 0;

    int          exp_sel_q [$];
    logic [31:0] exp_val_q [$];
    string       exp_name_q[$];
    logic [31:0] tx_q      [$];

    cpu_mem_bus #(
        .ADDR_BITS (ADDR_BITS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MMIO_BASE (BASE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_address(cpu_address),
        .cpu_datao  (cpu_datao),
        .cpu_rw     (cpu_rw),
        .cpu_data   (cpu_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: compare queued expectations and every TX handshake beat
    always @(negedge clock) begin
        while (exp_sel_q.size() > 0) begin
            int          sel;
            logic [31:0] exp;
            logic [31:0] act;
            string       nm;
            sel = exp_sel_q.pop_front();
            exp = exp_val_q.pop_front();
            nm  = exp_name_q.pop_front();
            case (sel)
                SEL_OVALID: act = {31'd0, out_valid};
                SEL_IREADY: act = {31'd0, in_ready};
                default:    act = cpu_data;
            endcase
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", nm, act, exp);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (tx_q.size() == 0) begin
                failures++;
                $display("FAIL tx_beat actual=%h required=no_beat", out_data);
            end else begin
                logic [31:0] e;
                e = tx_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL tx_beat actual=%h required=%h", out_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_sig(input int sel, input logic [31:0] v, input string nm);
        exp_sel_q.push_back(sel);
        exp_val_q.push_back(v);
        exp_name_q.push_back(nm);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] v, input string nm);
        cpu_address = addr;
        cpu_rw      = 1'b1;
        expect_sig(SEL_DATA, v, nm);
    endtask

    // One distinct TX write event followed by a RAM-address step to separate it from the next
    task automatic tx_write(input logic [31:0] v, input bit track);
        cpu_address = A_TX;
        cpu_rw      = 1'b0;
        cpu_datao   = v;
        if (track) tx_q.push_back(v);
        tick();
        cpu_address = 32'd3;
        tick();
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid) begin
            failures++;
            $display("FAIL %s_timeout actual=valid required=empty", nm);
        end
        checks++;
        if (tx_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing actual=%0d required=0", nm, tx_q.size());
            tx_q.delete();
        end
    endtask

    initial begin
        reset       = 1'b1;
        cpu_address = '0;
        cpu_datao   = '0;
        cpu_rw      = 1'b1;
        out_ready   = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        expect_sig(SEL_OVALID, 32'd0, "rst_out_valid");
        expect_sig(SEL_IREADY, 32'd1, "rst_in_ready");
        rd(A_STATUS, 32'h0000_0002, "rst_status");
        tick();

        // RAM path, aliasing, reserved holes, TX reads as 0
        cpu_address = 32'd5;
        cpu_rw      = 1'b0;
        cpu_datao   = 32'hDEAD_BEEF;
        tick(); tick(); tick();
        rd(32'd5, 32'hDEAD_BEEF, "ram_rd5");
        tick();
        rd(32'd5 + (32'd1 << ADDR_BITS), 32'hDEAD_BEEF, "ram_alias");
        tick();
        rd(BASE + 32'd5, 32'd0, "hole_rd");
        tick();
        rd(A_TX, 32'd0, "tx_rd_zero");
        tick();

        // Held write produces a single push; stepping away and back pushes again
        cpu_address = A_TX;
        cpu_rw      = 1'b0;
        cpu_datao   = 32'd7;
        tx_q.push_back(32'd7);
        tick(); tick(); tick(); tick();
        rd(A_STATUS, 32'h0000_0100, "single_write_cnt1");
        tick();
        cpu_address = 32'd3;
        cpu_rw      = 1'b0;
        tick();
        cpu_address = A_TX;
        cpu_datao   = 32'd8;
        tx_q.push_back(32'd8);
        tick();
        tick();
        rd(A_STATUS, 32'h0000_0200, "single_write_cnt2");
        tick();
        drain("drain_a");

        // Overflow: 9 pushes into 8 entries, STATUS read clears the sticky bit
        for (int i = 1; i <= 9; i++)
            tx_write(32'(i), i <= 8);
        rd(A_STATUS, 32'h0000_0805, "ovf_status");
        tick();
        expect_sig(SEL_DATA, 32'h0000_0801, "ovf_cleared");
        tick();
        drain("drain_ovf");

        // Full FIFO with simultaneous pop and push: the push is dropped
        for (int i = 0; i < 8; i++)
            tx_write(32'h10 + 32'(i), 1'b1);
        cpu_address = A_TX;
        cpu_rw      = 1'b0;
        cpu_datao   = 32'h0000_00AA;
        out_ready   = 1'b1;
        tick();
        out_ready = 1'b0;
        rd(A_STATUS, 32'h0000_0704, "full_simul_status");
        tick();
        drain("drain_full");

        // RX handshake and held-read single pop
        in_data  = 32'h0000_1234;
        in_valid = 1'b1;
        expect_sig(SEL_IREADY, 32'd1, "rx_ready_pre");
        tick();
        in_valid = 1'b0;
        expect_sig(SEL_IREADY, 32'd0, "rx_ready_full");
        rd(A_STATUS, 32'h0000_000A, "rx_status");
        tick();
        rd(A_RX, 32'h0000_1234, "rx_rd1");
        expect_sig(SEL_IREADY, 32'd0, "rx_ready_during_rd");
        tick();
        expect_sig(SEL_IREADY, 32'd1, "rx_ready_popped");
        expect_sig(SEL_DATA, 32'h0000_1234, "rx_hold_old");
        in_data  = 32'h0000_5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_sig(SEL_IREADY, 32'd0, "rx_recapture");
        expect_sig(SEL_DATA, 32'h0000_5678, "rx_rd2_held");
        tick();
        tick();
        expect_sig(SEL_IREADY, 32'd0, "rx_no_second_pop");
        rd(A_STATUS, 32'h0000_000A, "rx_status2");
        tick();
        rd(A_RX, 32'h0000_5678, "rx_rd3");
        tick();
        expect_sig(SEL_IREADY, 32'd1, "rx_ready_popped2");
        tick();

        // Reset mid-operation: FIFO and RX emptied, RAM retained
        tx_write(32'h21, 1'b0);
        tx_write(32'h22, 1'b0);
        tx_write(32'h23, 1'b0);
        in_data  = 32'h0000_0099;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_sig(SEL_OVALID, 32'd1, "pre_rst_valid");
        expect_sig(SEL_IREADY, 32'd0, "pre_rst_ready");
        rd(A_STATUS, 32'h0000_0308, "pre_rst_status");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_sig(SEL_OVALID, 32'd0, "mid_rst_valid");
        expect_sig(SEL_IREADY, 32'd1, "mid_rst_ready");
        rd(A_STATUS, 32'h0000_0002, "mid_rst_status");
        tick();
        rd(32'd5, 32'hDEAD_BEEF, "mid_rst_ram");
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_bus.md
Name: cpu_mem_bus

Overview:
- Memory/bus stage directly downstream of the `cpu` core; consumes its `address`, `datao` and `rw` outputs, and returns read data on the core's `data` input.
- Contains a word-addressed program/data RAM and three memory-mapped I/O words:
  - TX: output FIFO with a ready/valid drain port.
  - STATUS.
  - RX: single-entry input holding register with a ready/valid fill port.
- The core has no request strobe or stall, so this block detects write and RX-pop events itself and serves reads combinationally.

Parameters:
- ADDR_BITS, 10, RAM holds 2^ADDR_BITS 32-bit words; RAM index = cpu_address[ADDR_BITS-1:0].
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128.
- MMIO_BASE, 32'hFFFF_0000, word address of TX; STATUS = MMIO_BASE+1; RX = MMIO_BASE+2.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cpu_address  in  32  word address from core (`address`).
- cpu_datao  in  32  write data from core (`datao`).
- cpu_rw  in  1  1 = read, 0 = write (`rw`).
- cpu_data  out  32  read data to core (`data`), combinational.
- out_data  out  32  TX FIFO head.
- out_valid  out  1  TX FIFO non-empty.
- out_ready  in  1  sink accepts out_data.
- in_data  in  32  RX source data.
- in_valid  in  1  RX source offers in_data.
- in_ready  out  1  RX holding register empty.

Behaviour:
- Reset, all synchronous:
  - TX FIFO emptied (rd_ptr = wr_ptr = count = 0), out_valid = 0.
  - RX register emptied (rx_full = 0, rx_data = 0), in_ready = 1.
  - overflow sticky bit cleared; edge-detect history cleared (prev_rw = 1, prev_addr = 0).
  - RAM contents are not cleared.
  - Reset overrides every simultaneous event. Reset mid-drain: any beat not handshaken in that cycle is lost.
- Region decode:
  - MMIO when cpu_address is MMIO_BASE, MMIO_BASE+1 or MMIO_BASE+2.
  - MMIO_BASE+3 .. MMIO_BASE+15: reads return 0, writes are ignored.
  - Every other address is RAM; upper bits are ignored, so addresses alias.
- Read path (cpu_rw = 1), combinational, 0-cycle latency:
  - RAM: RAM word.
  - TX: 0.
  - STATUS: bit0 tx_full, bit1 tx_empty, bit2 overflow, bit3 rx_full, bits[15:8] tx_count, others 0.
  - RX: rx_data.
- Write event: a posedge where cpu_rw = 0 AND (prev_rw = 1 OR cpu_address != prev_addr).
  - Continuous low rw at one address performs exactly one write.
  - prev_rw and prev_addr are registered every cycle.
- Write actions:
  - RAM: word written, visible to a combinational read from the next cycle.
  - TX: push cpu_datao if not full. If full, the data is dropped and overflow is set.
  - STATUS, RX: write ignored.
- Read-side events (cpu_rw = 1) use the same edge rule (prev_rw = 0 OR address changed):
  - STATUS read event: clears overflow at that posedge. The value read that cycle still shows overflow = 1.
  - RX read event: pops RX (rx_full <= 0) at that posedge. cpu_data shows rx_data during the cycle.
- TX FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - out_data = mem[rd_ptr]; out_valid = (count != 0). Pop on out_valid && out_ready.
  - Full is evaluated on the pre-edge count. When full, a simultaneous push and pop pops and drops the push (overflow set, count = DEPTH-1).
  - When not full and not empty, a simultaneous push and pop leaves count unchanged.
  - Pushing into an empty FIFO: out_valid rises on the next cycle (1-cycle latency). No bypass.
- RX register:
  - in_ready = ~rx_full. Capture on in_valid && in_ready: rx_data <= in_data, rx_full <= 1.
  - Pop and capture in the same cycle is impossible, because in_ready is low while rx_full = 1.
  - rx_data holds its old value after a pop.
- No X on outputs after reset. Unused STATUS bits read as 0.

Test Plan:
- RAM path: reset; write 32'hDEAD_BEEF to addr 5 (rw low 3 cycles); then rw = 1 addr 5 -> cpu_data = DEADBEEF same cycle; addr 5+2^ADDR_BITS also reads DEADBEEF.
- Single-write rule: hold rw = 0 at TX with datao = 7 for 4 cycles, out_ready = 0 -> tx_count = 1 (STATUS[15:8] = 1); then address steps TX, 3, TX with rw low -> count = 2.
- Overflow: out_ready = 0; 9 distinct TX write events of 1..9 (DEPTH = 8) -> STATUS = 0x0805 (full, overflow); STATUS read event -> next STATUS read = 0x0801; drain out_ready = 1 -> out_data sequence 1..8, out_valid low after the 8th beat.
- Full + simultaneous: FIFO full, out_ready = 1, TX write of 0xAA in the same cycle -> count = 7, overflow = 1, 0xAA never appears on out_data.
- RX handshake: in_valid = 1, in_data = 0x1234 -> in_ready drops the next cycle, STATUS bit3 = 1; CPU read of RX -> cpu_data = 0x1234, in_ready = 1 the following cycle; a held read of RX produces no second pop of a newly captured 0x5678 until the address or rw changes.
- Reset mid-operation: FIFO holding 3 entries and RX full; assert reset for 1 cycle -> out_valid = 0, in_ready = 1, STATUS = 0x0002; RAM word 5 still DEADBEEF.
